// File: rtl/vfu_request_queue.sv
`default_nettype none
// ============================================================================
// Module      : vfu_request_queue
// Description : FIFO of packed slot requests toward the VFU, with an
//               outstanding-request credit limit and a queue flush.
// Revision    : 1.0 - initial release
// ============================================================================
module vfu_request_queue #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int W               = 204
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [W-1:0]                         in_bits,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [W-1:0]                         out_bits,
  input  logic                                 resp_valid,
  input  logic                                 flush,
  output logic [$clog2(DEPTH+1)-1:0]           count,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                 idle,
  output logic                                 resp_err
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0] c_full     = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [OUT_W-1:0] c_max_out  = OUT_W'(MAX_OUTSTANDING);
  localparam logic [OUT_W-1:0] c_out_one  = OUT_W'(1);
  localparam logic [PTR_W-1:0] c_ptr_one  = PTR_W'(1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wp_q, wp_d;
  logic [PTR_W-1:0] rp_q, rp_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic             resp_err_q, resp_err_d;
  logic             enq, deq;

  // Handshake qualifiers depend only on registered state, flush and reset,
  // so a full queue never opens a slot on the cycle it is drained.
  assign in_ready  = !reset && !flush && (count_q < c_full);
  assign out_valid = !flush && (count_q != '0) && (outstanding_q < c_max_out);
  assign enq       = in_valid && in_ready;
  assign deq       = out_valid && out_ready;
  assign out_bits  = mem_q[rp_q];

  assign count       = count_q;
  assign outstanding = outstanding_q;
  assign idle        = (count_q == '0) && (outstanding_q == '0);
  assign resp_err    = resp_err_q;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (enq) wp_d = wp_q + c_ptr_one;
      if (deq) rp_d = rp_q + c_ptr_one;
      case ({enq, deq})
        2'b10:   count_d = count_q + c_cnt_one;
        2'b01:   count_d = count_q - c_cnt_one;
        default: count_d = count_q;
      endcase
    end
  end

  // A response with nothing outstanding is flagged and not counted; if it
  // coincides with an issue, only the issue is accounted for.
  always_comb begin
    outstanding_d = outstanding_q;
    case ({deq, resp_valid})
      2'b10: outstanding_d = outstanding_q + c_out_one;
      2'b01: if (outstanding_q != '0) outstanding_d = outstanding_q - c_out_one;
      2'b11: if (outstanding_q == '0) outstanding_d = c_out_one;
      default: outstanding_d = outstanding_q;
    endcase
    resp_err_d = resp_err_q || (resp_valid && (outstanding_q == '0));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp_q          <= '0;
      rp_q          <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      resp_err_q    <= 1'b0;
    end else begin
      wp_q          <= wp_d;
      rp_q          <= rp_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      resp_err_q    <= resp_err_d;
    end
  end

  always_ff @(posedge clock) begin
    if (enq) mem_q[wp_q] <= in_bits;
  end

endmodule
`default_nettype wire

// File: tb/tb_vfu_request_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_vfu_request_queue
// Description : Directed table-driven bench for vfu_request_queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vfu_request_queue;

  localparam int DEPTH = 4;
  localparam int MAXO  = 4;
  localparam int W     = 204;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_bits = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_bits;
  logic         resp_valid = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   count;
  logic [2:0]   outstanding;
  logic         idle;
  logic         resp_err;

  int errs   = 0;
  int checks = 0;

  vfu_request_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .W(W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
    .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
    .resp_valid(resp_valid), .flush(flush),
    .count(count), .outstanding(outstanding), .idle(idle), .resp_err(resp_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit iv; int id; bit ordy; bit rv; bit fl;
    bit irdy; bit ov; int cnt; int outs; bit idl; bit err; int oid;
  } vec_t;

  vec_t vecs[$];

  // Distinct payload per request id; the tag field carries id[1:0].
  function automatic logic [W-1:0] mk(input int k);
    logic [W-1:0] p;
    logic [31:0]  wd;
    for (int b = 0; b < W; b++) begin
      wd   = (32'(k) * 32'h9E3779B9) ^ (32'(b / 32) * 32'h01010101) ^ 32'h5A5AC3C3;
      p[b] = wd[b % 32];
    end
    p[1:0] = 2'(k);
    return p;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input bit iv, input int id, input bit ordy, input bit rv, input bit fl,
                     input bit irdy, input bit ov, input int cnt, input int outs,
                     input bit idl, input bit err, input int oid);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy; v.rv = rv; v.fl = fl;
    v.irdy = irdy; v.ov = ov; v.cnt = cnt; v.outs = outs; v.idl = idl; v.err = err; v.oid = oid;
    vecs.push_back(v);
  endtask

  task automatic check_state(input string tg, input bit irdy, input bit ov, input int cnt,
                             input int outs, input bit idl, input bit err, input int oid);
    chk({tg, " in_ready"},    W'(in_ready),    W'(irdy));
    chk({tg, " out_valid"},   W'(out_valid),   W'(ov));
    chk({tg, " count"},       W'(count),       W'(cnt));
    chk({tg, " outstanding"}, W'(outstanding), W'(outs));
    chk({tg, " idle"},        W'(idle),        W'(idl));
    chk({tg, " resp_err"},    W'(resp_err),    W'(err));
    if (oid >= 0) chk({tg, " out_bits"}, out_bits, mk(oid));
  endtask

  initial begin
    // iv id ordy rv fl | in_ready out_valid count outstanding idle resp_err head_id
    // FIFO order / latency
    add(1, 0,1,0,0, 1,0,0,0,1,0,-1);
    add(1, 1,1,0,0, 1,1,1,0,0,0, 0);
    add(1, 2,1,1,0, 1,1,1,1,0,0, 1);
    add(1, 3,1,1,0, 1,1,1,1,0,0, 2);
    add(0, 0,1,1,0, 1,1,1,1,0,0, 3);
    add(0, 0,0,1,0, 1,0,0,1,0,0,-1);
    add(0, 0,0,0,0, 1,0,0,0,1,0,-1);
    // full queue, held 5th request, pointer wrap
    add(1, 4,0,0,0, 1,0,0,0,1,0,-1);
    add(1, 5,0,0,0, 1,1,1,0,0,0, 4);
    add(1, 6,0,0,0, 1,1,2,0,0,0, 4);
    add(1, 7,0,0,0, 1,1,3,0,0,0, 4);
    add(1, 8,0,0,0, 0,1,4,0,0,0, 4);
    add(1, 8,1,0,0, 0,1,4,0,0,0, 4);
    add(1, 8,0,0,0, 1,1,3,1,0,0, 5);
    add(0, 0,1,1,0, 0,1,4,1,0,0, 5);
    add(0, 0,1,1,0, 1,1,3,1,0,0, 6);
    add(0, 0,1,1,0, 1,1,2,1,0,0, 7);
    add(0, 0,1,1,0, 1,1,1,1,0,0, 8);
    add(0, 0,0,1,0, 1,0,0,1,0,0,-1);
    // outstanding limit and credit return
    add(1, 9,1,0,0, 1,0,0,0,1,0,-1);
    add(1,10,1,0,0, 1,1,1,0,0,0, 9);
    add(1,11,1,0,0, 1,1,1,1,0,0,10);
    add(1,12,1,0,0, 1,1,1,2,0,0,11);
    add(1,13,1,0,0, 1,1,1,3,0,0,12);
    add(1,14,1,0,0, 1,0,1,4,0,0,-1);
    add(0, 0,1,1,0, 1,0,2,4,0,0,-1);
    add(0, 0,1,0,0, 1,1,2,3,0,0,13);
    add(0, 0,1,0,0, 1,0,1,4,0,0,-1);
    // flush with count=3, outstanding=2; in_valid during flush dropped
    add(1,15,0,1,0, 1,0,1,4,0,0,-1);
    add(1,16,0,1,0, 1,1,2,3,0,0,14);
    add(1,17,1,0,1, 0,0,3,2,0,0,-1);
    add(0, 0,0,1,0, 1,0,0,2,0,0,-1);
    add(0, 0,0,1,0, 1,0,0,1,0,0,-1);
    add(1,18,0,0,0, 1,0,0,0,1,0,-1);
    add(0, 0,0,0,0, 1,1,1,0,0,0,18);
    add(0, 0,1,0,0, 1,1,1,0,0,0,18);
    add(0, 0,0,1,0, 1,0,0,1,0,0,-1);
    // spurious response, then response coinciding with issue at outstanding=0
    add(0, 0,0,1,0, 1,0,0,0,1,0,-1);
    add(1,19,0,0,0, 1,0,0,0,1,1,-1);
    add(0, 0,1,1,0, 1,1,1,0,0,1,19);
    // build count=2, outstanding=3 for the async reset
    add(1,20,0,0,0, 1,0,0,1,0,1,-1);
    add(1,21,1,0,0, 1,1,1,1,0,1,20);
    add(1,22,1,0,0, 1,1,1,2,0,1,21);
    add(1,23,0,0,0, 1,1,1,3,0,1,22);
    add(0, 0,0,0,0, 1,1,2,3,0,1,22);

    @(negedge clock);
    #1 check_state("reset", 0, 0, 0, 0, 1, 0, -1);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      in_valid   = vecs[i].iv;
      in_bits    = mk(vecs[i].id);
      out_ready  = vecs[i].ordy;
      resp_valid = vecs[i].rv;
      flush      = vecs[i].fl;
      #1 check_state($sformatf("v%0d", i), vecs[i].irdy, vecs[i].ov, vecs[i].cnt,
                     vecs[i].outs, vecs[i].idl, vecs[i].err, vecs[i].oid);
    end

    // asynchronous reset between edges
    @(posedge clock);
    #2 reset = 1'b1;
    #1 check_state("async_rst", 0, 0, 0, 0, 1, 0, -1);
    @(negedge clock);
    reset = 1'b0;
    #1 check_state("post_rst", 1, 0, 0, 0, 1, 0, -1);
    in_valid = 1'b1;
    in_bits  = mk(24);
    #1 chk("post_rst no_bypass", W'(out_valid), W'(0));
    @(negedge clock);
    in_valid = 1'b0;
    #1 check_state("post_rst enq", 1, 1, 1, 0, 0, 0, 24);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vfu_request_queue.md
# vfu_request_queue

Buffering and flow-control stage directly downstream of the single-input slot-request arbiter in the lane and upstream of the VFU issue port. It holds up to DEPTH packed slot requests to the VFU in a first-in-first-out queue. It limits the number of requests issued but not yet answered to MAX_OUTSTANDING, using VFU response strobes. It also supports a flush of queued (not yet issued) requests.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, ≥2.
- MAX_OUTSTANDING, 4, maximum issued-but-unanswered requests; ≥1.
- W, 204, payload width. Packing from MSB to LSB: src_0, src_1, src_2, src_3 (33 each), opcode, mask, executeMask (4 each), sign0, sign, reverse, average, saturate (1 each), vxrm, vSew (2 each), shifterSize (20), rem (1), executeIndex (2), popInit (10), groupIndex (6), laneIndex (2), maskType, narrow (1 each), unitSelet (2), floatMul (1), roundingMode (3), tag (2, LSBs).

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  request from the arbiter is valid.
- in_ready  out  1  queue accepts a request.
- in_bits  in  W  packed request.
- out_valid  out  1  request is offered to the VFU.
- out_ready  in  1  VFU accepts the request.
- out_bits  out  W  packed request at the queue head.
- resp_valid  in  1  VFU reports one request complete.
- flush  in  1  discard all queued entries.
- count  out  clog2(DEPTH+1)  number of queued entries.
- outstanding  out  clog2(MAX_OUTSTANDING+1)  number of issued, unanswered requests.
- idle  out  1  high when count==0 and outstanding==0.
- resp_err  out  1  sticky flag: resp_valid arrived while outstanding==0.

## Operation
- Storage is a circular buffer: DEPTH×W array, write pointer wp, read pointer rp, and a count register. Pointers wrap modulo DEPTH.
- Handshakes:
  - enq = in_valid && in_ready.
  - deq = out_valid && out_ready.
- in_ready = !reset && !flush && (count < DEPTH). It depends only on registered state and flush, never on out_ready. When the queue is full, a same-cycle dequeue does not open a slot.
- out_valid = !flush && (count != 0) && (outstanding < MAX_OUTSTANDING).
- out_bits = mem[rp], fall-through. Contents are don't-care while out_valid=0.
- On enq: mem[wp] ← in_bits, wp += 1.
- On deq: rp += 1.
- count update: +1 on enq only, −1 on deq only, unchanged when both occur.
- outstanding update (registered):
  - +1 on deq only.
  - −1 on resp_valid only when outstanding > 0.
  - Unchanged when deq and resp_valid occur together.
  - resp_valid when outstanding==0 sets resp_err. If that cycle also has a deq, outstanding becomes 1.
- flush (one cycle): wp ← 0, rp ← 0, count ← 0. The same cycle has no enq and no deq (both forced low). outstanding still updates on resp_valid. A request in flight to the VFU is not recalled.
- Payload is never inspected or modified. The tag and every other field pass through bit-exact.
- Order is strictly FIFO. No reordering by tag.

## Timing
- Reset values: wp=rp=0, count=0, outstanding=0, resp_err=0, in_ready=0 while reset is high, out_valid=0, idle=1. Array contents are not reset.
- Reset asserted mid-operation clears all state immediately, with no clock needed. in_ready rises in the first cycle after reset deasserts.
- Latency: a request enqueued at edge N can be presented on out_valid from cycle N+1. There is no combinational in→out bypass, even when the queue is empty.
- Throughput: one enq and one deq per cycle are sustained when 0 < count < DEPTH and outstanding < MAX_OUTSTANDING, or when outstanding is held constant by matching resp_valid.
- Credit return: resp_valid at edge N can allow out_valid in cycle N+1. It has no same-cycle effect on out_valid.
- Boundary conditions:
  - Full: in_ready=0.
  - Empty: out_valid=0.
  - Outstanding at limit: out_valid=0 while count > 0.
  - Pointer wrap from DEPTH−1 to 0 preserves order.
- count, outstanding, idle and resp_err are all registered-state outputs.

## Test plan
- FIFO order and latency: enqueue tags 0,1,2,3 back-to-back with out_ready=1 and resp_valid=1 every cycle. out_bits shows tags 0,1,2,3 in cycles 1–4, with payloads bit-exact.
- Full queue: hold out_ready=0 and enqueue 5 requests. in_ready drops after the 4th, count=4, the 5th is held. Then pulse out_ready for 1 cycle: count=3 and in_ready=1 on the next cycle.
- Outstanding limit: hold out_ready=1 with resp_valid=0 and queue 6 requests. Exactly 4 are issued, outstanding=4, out_valid=0 with count=2. One resp_valid pulse lets exactly one more issue on the following cycle.
- Flush: with count=3 and outstanding=2, assert flush for 1 cycle. Then count=0, pointers are 0, outstanding=2, and an in_valid in the flush cycle is dropped. Two resp_valid pulses then give idle=1.
- Spurious response: resp_valid with outstanding=0 sets resp_err=1, and outstanding stays 0. resp_err persists until reset.
- Async reset mid-traffic: assert reset between edges with count=2 and outstanding=3. All outputs take their reset values immediately. After deassert, an enqueued request appears one cycle later.
